// File: rtl/ldpc_pkg.sv
// Shared types and helpers for the min-sum LDPC decoder datapath.
package ldpc_pkg;

    localparam int MSG_W_DEF = 8;

    typedef logic signed [MSG_W_DEF-1:0] msg_t;

    localparam msg_t MSG_MAX = msg_t'((1 << (MSG_W_DEF - 1)) - 1);

    typedef enum logic {
        ACCUM,
        EMIT
    } vn_state_t;

    // Symmetric clip to +/-(2^(w-1)-1): the most negative code is never produced.
    function automatic logic signed [31:0] sat_clip(input logic signed [31:0] v, input int w);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic msg_t sat_msg(input logic signed [31:0] v);
        return msg_t'(sat_clip(v, MSG_W_DEF));
    endfunction

endpackage

// File: rtl/vn_msg_buffer.sv
// Per-VN check-to-variable message store: sequential write pointer, random read index.
module vn_msg_buffer #(
    parameter int MAX_DEG = 8,
    parameter int MSG_W   = 8,
    localparam int CNT_W  = $clog2(MAX_DEG + 1),
    localparam int IDX_W  = $clog2(MAX_DEG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic signed [MSG_W-1:0] wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [CNT_W-1:0]        wr_ptr,
    output logic signed [MSG_W-1:0] rd_data
);

    logic signed [MSG_W-1:0] mem [MAX_DEG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; every entry is written before it is read within a VN.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[IDX_W-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/vn_update_engine.sv
// Serial min-sum variable-node update: accumulate one VN's edges, then emit extrinsic messages.
module vn_update_engine
    import ldpc_pkg::*;
#(
    parameter int N_V     = 44,
    parameter int MAX_DEG = 8,
    parameter int MSG_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [MSG_W-1:0] llr,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [MSG_W-1:0] s_msg,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [MSG_W-1:0] m_msg,
    output logic                    m_last,
    output logic                    post_valid,
    output logic signed [MSG_W-1:0] post_llr,
    output logic                    hard_bit,
    output logic [$clog2(N_V)-1:0]  vn_idx,
    output logic                    deg_err,
    output logic                    frame_done
);

    localparam int SUM_W = MSG_W + $clog2(MAX_DEG + 1) + 1;
    localparam int CNT_W = $clog2(MAX_DEG + 1);
    localparam int IDX_W = $clog2(MAX_DEG);
    localparam int VN_W  = $clog2(N_V);

    function automatic logic signed [MSG_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        return MSG_W'(sat_clip(32'(v), MSG_W));
    endfunction

    vn_state_t               state;
    logic signed [SUM_W-1:0] sum;
    logic [CNT_W-1:0]        k;
    logic [CNT_W-1:0]        wr_ptr;
    logic [IDX_W-1:0]        rd_idx;
    logic signed [MSG_W-1:0] rd_data;

    logic                    s_fire;
    logic                    m_fire;
    logic                    first;
    logic                    close;
    logic                    buf_clr;
    logic signed [SUM_W-1:0] sum_nxt;
    logic signed [MSG_W-1:0] first_sub;
    logic signed [MSG_W-1:0] out_first;
    logic signed [MSG_W-1:0] out_next;

    assign s_fire  = s_valid && s_ready;
    assign m_fire  = m_valid && m_ready;
    assign first   = (wr_ptr == '0);
    assign close   = s_fire && (s_last || wr_ptr == CNT_W'(MAX_DEG - 1));
    assign buf_clr = (state == EMIT) && m_fire && m_last;

    assign sum_nxt = first ? (SUM_W'(llr) + SUM_W'(s_msg)) : (sum + SUM_W'(s_msg));

    // A degree-1 VN closes on its first beat, before buf[0] holds anything.
    assign first_sub = first ? s_msg : rd_data;
    assign out_first = sat(sum_nxt - SUM_W'(first_sub));
    assign out_next  = sat(sum - SUM_W'(rd_data));

    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
        rd_idx = '0;
        if (state == EMIT) begin
            rd_idx = IDX_W'(k + 1'b1);
        end
    end

    vn_msg_buffer #(
        .MAX_DEG (MAX_DEG),
        .MSG_W   (MSG_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (s_fire),
        .wr_data (s_msg),
        .rd_idx  (rd_idx),
        .wr_ptr  (wr_ptr),
        .rd_data (rd_data)
    );

    // NOTE: state and registered outputs use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ACCUM;
            s_ready    <= 1'b1;
            m_valid    <= 1'b0;
            m_msg      <= '0;
            m_last     <= 1'b0;
            post_valid <= 1'b0;
            post_llr   <= '0;
            hard_bit   <= 1'b0;
            vn_idx     <= '0;
            deg_err    <= 1'b0;
            frame_done <= 1'b0;
            sum        <= '0;
            k          <= '0;
        end else begin
            post_valid <= 1'b0;
            deg_err    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ACCUM: begin
                    if (s_fire) begin
                        sum <= sum_nxt;
                        if (close) begin
                            state      <= EMIT;
                            s_ready    <= 1'b0;
                            m_valid    <= 1'b1;
                            m_msg      <= out_first;
                            m_last     <= first;
                            post_valid <= 1'b1;
                            post_llr   <= sat(sum_nxt);
                            hard_bit   <= sum_nxt[SUM_W-1];
                            deg_err    <= !s_last;
                            k          <= '0;
                        end
                    end
                end
                EMIT: begin
                    if (m_fire) begin
                        if (m_last) begin
                            state      <= ACCUM;
                            s_ready    <= 1'b1;
                            m_valid    <= 1'b0;
                            m_last     <= 1'b0;
                            sum        <= '0;
                            frame_done <= (vn_idx == VN_W'(N_V - 1));
                            vn_idx     <= (vn_idx == VN_W'(N_V - 1)) ? '0 : vn_idx + 1'b1;
                        end else begin
                            // wr_ptr equals the VN degree while emitting.
                            k      <= k + 1'b1;
                            m_msg  <= out_next;
                            m_last <= (k + CNT_W'(2) == wr_ptr);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vn_update_engine.sv
// Self-checking bench for vn_update_engine: directed vector table, reset corner case, random VNs.
module tb_vn_update_engine;

    localparam int N_V     = 3;
    localparam int MAX_DEG = 4;
    localparam int MSG_W   = 8;

    typedef struct packed {
        logic signed [7:0] llr;
        int                deg;
        logic [3:0][7:0]   msg;
        bit                with_last;
        int                stall_at;
        int                stall_n;
        logic [3:0][7:0]   exp;
        logic signed [7:0] post;
        bit                hard;
        bit                derr;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic signed [MSG_W-1:0] llr = '0;
    logic                    s_valid = 1'b0;
    logic                    s_ready;
    logic signed [MSG_W-1:0] s_msg = '0;
    logic                    s_last = 1'b0;
    logic                    m_valid;
    logic                    m_ready = 1'b1;
    logic signed [MSG_W-1:0] m_msg;
    logic                    m_last;
    logic                    post_valid;
    logic signed [MSG_W-1:0] post_llr;
    logic                    hard_bit;
    logic [1:0]              vn_idx;
    logic                    deg_err;
    logic                    frame_done;

    int checks = 0;
    int errors = 0;
    int exp_vn = 0;

    always #5 clk = ~clk;

    vn_update_engine #(
        .N_V     (N_V),
        .MAX_DEG (MAX_DEG),
        .MSG_W   (MSG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .llr        (llr),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_msg      (s_msg),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_msg      (m_msg),
        .m_last     (m_last),
        .post_valid (post_valid),
        .post_llr   (post_llr),
        .hard_bit   (hard_bit),
        .vn_idx     (vn_idx),
        .deg_err    (deg_err),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clip(input int v);
        if (v > 127) return 127;
        if (v < -127) return -127;
        return v;
    endfunction

    // Reference: extrinsic = clip(llr + all messages - own message), posterior = clip(total).
    function automatic vec_t model(input vec_t v);
        int total;
        total = int'(v.llr);
        for (int i = 0; i < v.deg; i++) total += int'($signed(v.msg[i]));
        for (int i = 0; i < v.deg; i++) v.exp[i] = 8'(clip(total - int'($signed(v.msg[i]))));
        v.post = 8'(clip(total));
        v.hard = (total < 0);
        v.derr = !v.with_last;
        return v;
    endfunction

    function automatic vec_t mk(input int l, input int d, input int m0, input int m1, input int m2,
                                input int m3, input bit wl, input int sa, input int sn, input int e0,
                                input int e1, input int e2, input int e3, input int p, input bit h,
                                input bit de);
        vec_t v;
        v = '0;
        v.llr = l[7:0];
        v.deg = d;
        v.msg[0] = m0[7:0]; v.msg[1] = m1[7:0]; v.msg[2] = m2[7:0]; v.msg[3] = m3[7:0];
        v.with_last = wl;
        v.stall_at = sa;
        v.stall_n = sn;
        v.exp[0] = e0[7:0]; v.exp[1] = e1[7:0]; v.exp[2] = e2[7:0]; v.exp[3] = e3[7:0];
        v.post = p[7:0];
        v.hard = h;
        v.derr = de;
        return v;
    endfunction

    task automatic send_beats(input vec_t v, input string tag);
        check({tag, " vn_idx"}, 32'(vn_idx), exp_vn);
        check({tag, " s_ready_idle"}, 32'(s_ready), 1);
        for (int i = 0; i < v.deg; i++) begin
            llr     = v.llr;
            s_msg   = $signed(v.msg[i]);
            s_last  = v.with_last && (i == v.deg - 1);
            s_valid = 1'b1;
            @(posedge clk);
            #1;
            if (i < v.deg - 1) check({tag, " m_valid_accum"}, 32'(m_valid), 0);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int got;
        int cyc;
        int stalled;
        send_beats(v, tag);
        check({tag, " post_valid"}, 32'(post_valid), 1);
        check({tag, " post_llr"}, post_llr, v.post);
        check({tag, " hard_bit"}, 32'(hard_bit), 32'(v.hard));
        check({tag, " deg_err"}, 32'(deg_err), 32'(v.derr));
        got = 0;
        cyc = 0;
        stalled = 0;
        while (got < v.deg && cyc < 40) begin
            check($sformatf("%s m_valid[%0d]", tag, got), 32'(m_valid), 1);
            check($sformatf("%s s_ready_emit[%0d]", tag, got), 32'(s_ready), 0);
            check($sformatf("%s m_msg[%0d]", tag, got), m_msg, $signed(v.exp[got]));
            check($sformatf("%s m_last[%0d]", tag, got), 32'(m_last), 32'(got == v.deg - 1));
            if (got == v.stall_at && stalled < v.stall_n) begin
                m_ready = 1'b0;
                stalled++;
            end else begin
                m_ready = 1'b1;
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) check({tag, " post_pulse_end"}, 32'(post_valid), 0);
        end
        if (got < v.deg) check({tag, " emit_timeout"}, got, v.deg);
        m_ready = 1'b1;
        check({tag, " frame_done"}, 32'(frame_done), 32'(exp_vn == N_V - 1));
        check({tag, " m_valid_after"}, 32'(m_valid), 0);
        check({tag, " s_ready_after"}, 32'(s_ready), 1);
        exp_vn = (exp_vn + 1) % N_V;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        vec_t r;

        tbl[0] = mk(10, 3, 5, -3, 7, 0, 1, 0, 0, 14, 22, 12, 0, 19, 0, 0);
        tbl[1] = mk(127, 2, 100, 100, 0, 0, 1, 0, 0, 127, 127, 0, 0, 127, 0, 0);
        tbl[2] = mk(-100, 2, -100, -100, 0, 0, 1, 0, 0, -127, -127, 0, 0, -127, 1, 0);
        tbl[3] = mk(10, 3, 5, -3, 7, 0, 1, 1, 3, 14, 22, 12, 0, 19, 0, 0);
        tbl[4] = mk(-5, 1, 50, 0, 0, 0, 1, 0, 0, -5, 0, 0, 0, 45, 0, 0);
        tbl[5] = mk(0, 4, 1, 2, 3, 4, 0, 0, 0, 9, 8, 7, 6, 10, 0, 1);
        tbl[6] = mk(3, 2, 4, -6, 0, 0, 1, 0, 0, -3, 7, 0, 0, 1, 0, 0);
        tbl[7] = mk(-20, 2, 10, 5, 0, 0, 1, 0, 0, -15, -10, 0, 0, -5, 1, 0);
        tbl[8] = mk(0, 2, -1, -1, 0, 0, 1, 0, 0, -1, -1, 0, 0, -2, 1, 0);
        tbl[9] = mk(64, 2, 64, 64, 0, 0, 1, 0, 0, 127, 127, 0, 0, 127, 0, 0);

        #12;
        check("rst s_ready", 32'(s_ready), 1);
        check("rst m_valid", 32'(m_valid), 0);
        check("rst post_valid", 32'(post_valid), 0);
        check("rst vn_idx", 32'(vn_idx), 0);
        check("rst deg_err", 32'(deg_err), 0);
        check("rst frame_done", 32'(frame_done), 0);
        check("rst m_msg", m_msg, 0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset while a VN is stalled in its emit phase.
        send_beats(tbl[0], "rst_mid");
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid m_valid_before", 32'(m_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid m_valid", 32'(m_valid), 0);
        check("rst_mid s_ready", 32'(s_ready), 1);
        check("rst_mid vn_idx", 32'(vn_idx), 0);
        check("rst_mid post_valid", 32'(post_valid), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        m_ready = 1'b1;
        exp_vn = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("rst_mid no_residual m_valid", 32'(m_valid), 0);
            check("rst_mid no_residual post_valid", 32'(post_valid), 0);
        end
        run_vec(tbl[0], "post_rst");

        for (int n = 0; n < 40; n++) begin
            r = '0;
            r.deg = int'($urandom_range(1, MAX_DEG));
            r.llr = 8'($urandom);
            for (int i = 0; i < r.deg; i++) r.msg[i] = 8'($urandom);
            r.with_last = (r.deg < MAX_DEG) ? 1'b1 : 1'($urandom_range(0, 1));
            r.stall_at = int'($urandom_range(0, r.deg - 1));
            r.stall_n = int'($urandom_range(0, 2));
            r = model(r);
            run_vec(r, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vn_update_engine.md
Name: vn_update_engine

Overview:
- Streaming, parametrised variable-node update for the odd (VN) layer of the min-sum decoder.
- Receives check-to-variable messages grouped per variable node, with that node's channel LLR.
- Emits one saturated extrinsic variable-to-check message per edge, plus the posterior LLR and hard decision.
- Replaces the fully combinational all-edges VN layer with a serial, back-pressurable unit whose area scales with MAX_DEG, not E.

Parameters:
- N_V, 44, variable nodes per frame; sets vn_idx range and frame wrap.
- MAX_DEG, 8, maximum VN degree; sets message buffer depth.
- MSG_W, 8, signed message and LLR width.
- SUM_W, MSG_W+$clog2(MAX_DEG+1)+1, internal accumulator width (derived; no override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- llr  in  MSG_W signed  channel LLR of current VN; sampled on the first accepted beat of each VN.
- s_valid  in  1  input message valid.
- s_ready  out  1  engine can accept a message.
- s_msg  in  MSG_W signed  check-to-variable message.
- s_last  in  1  marks last edge of current VN.
- m_valid  out  1  output message valid.
- m_ready  in  1  downstream accepts.
- m_msg  out  MSG_W signed  extrinsic variable-to-check message.
- m_last  out  1  last edge of current VN.
- post_valid  out  1  one-cycle pulse: post_llr/hard_bit valid.
- post_llr  out  MSG_W signed  saturated posterior LLR.
- hard_bit  out  1  1 when posterior sum < 0.
- vn_idx  out  $clog2(N_V)  index of the VN being processed.
- deg_err  out  1  one-cycle pulse: MAX_DEG beats accepted without s_last.
- frame_done  out  1  one-cycle pulse on final output handshake of VN N_V-1.

Behaviour:
- Reset values: all outputs 0 except s_ready=1; state ACCUM, cnt=0, vn_idx=0, accumulator=0.
- Reset is asynchronous and may hit any state; in-flight data is discarded, with no partial output after release.
- Handshake: transfer when valid && ready. m_msg, m_last and m_valid are held stable while m_valid && !m_ready.
- State ACCUM:
  - s_ready=1, m_valid=0.
  - On the first beat: sum = sext(llr) + sext(s_msg).
  - On later beats: sum += sext(s_msg).
  - Each beat stores s_msg in buf[cnt] and increments cnt.
  - On an accepted beat with s_last, or when cnt reaches MAX_DEG (deg_err=1 in that case), go to EMIT with deg=cnt+1.
- State EMIT:
  - s_ready=0.
  - m_msg = sat(sum - sext(buf[k])), where k counts 0..deg-1; m_last = (k==deg-1).
  - Outputs are registered: first m_valid is asserted in the cycle after the last input beat is accepted.
  - post_valid pulses in that same first EMIT cycle, with post_llr=sat(sum) and hard_bit=sum[SUM_W-1].
  - On handshake with m_last: return to ACCUM with cnt=0, and vn_idx increments, wrapping N_V-1 -> 0 with a frame_done pulse.
- sat():
  - Symmetric clip to [-(2^(MSG_W-1)-1), +(2^(MSG_W-1)-1)]; -2^(MSG_W-1) is never emitted.
  - Input -128 (MSG_W=8) is accepted as-is in arithmetic.
- Degree-1 VN: m_msg = sat(llr).
- Throughput: deg input cycles + deg output cycles per VN when never stalled. No overlap of ACCUM and EMIT.
- SUM_W guarantees no internal overflow for MAX_DEG+1 addends.

Decomposition:
- Package ldpc_pkg holds:
  - msg_t (logic signed [MSG_W-1:0]).
  - Function sat_msg(sum) implementing the symmetric clip.
  - Constant MSG_MAX.
  - State enum vn_state_t {ACCUM, EMIT}.
- One natural sub-module, vn_msg_buffer: a MAX_DEG-deep register file with write pointer and read index. The FSM, accumulator and saturation stay in the top.

Test Plan (MSG_W=8, MAX_DEG=4, N_V=3):
1. llr=10; msgs 5, -3, 7(last); m_ready=1 -> m_msg 14, 22, 12; m_last on 12; post_llr=19, hard_bit=0; first m_valid 1 cycle after last beat.
2. llr=127; msgs 100, 100(last) -> m_msg 127, 127; post_llr=127. Then llr=-100; msgs -100, -100(last) -> m_msg -127, -127; post_llr=-127; hard_bit=1.
3. Test 1 stimulus with m_ready low for 3 cycles while m_msg=22 -> m_msg stays 22 and m_valid stays 1; sequence 14, 22, 12 intact; s_ready stays 0 throughout.
4. Degree-1: llr=-5, msg 50(last) -> single m_msg=-5 with m_last=1; post_llr=45, hard_bit=0.
5. Four beats 1, 2, 3, 4 with s_last=0, llr=0 -> deg_err pulse on 4th beat; outputs 9, 8, 7, 6 with m_last on 6.
6. Three degree-2 VNs -> vn_idx steps 0, 1, 2, 0; frame_done pulses once on the last handshake of VN 2. Then assert rst mid-EMIT -> m_valid=0, s_ready=1, vn_idx=0 immediately; no residual outputs after release.
